// File: rtl/ibex_pkg.sv
// Shared types for the Ibex register-file writeback path.
// Holds the writeback source/tracker enums and the RV32E address-folding helper.
package ibex_pkg;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_LSU,
    WB_SKID,
    WB_EX
  } wb_src_e;

  typedef enum logic {
    LD_IDLE,
    LD_WAIT
  } ld_state_e;

  // With RV32E only x0..x15 exist, so bit 4 of every register address is dropped.
  function automatic logic [4:0] wb_addr_mask(input logic [4:0] addr, input bit rv32e);
    return rv32e ? {1'b0, addr[3:0]} : addr;
  endfunction

endpackage

// File: rtl/ibex_rf_wb_skid.sv
// One-entry holding register for an execute result that lost the write port
// to a load response. Load takes precedence over clear.
module ibex_rf_wb_skid #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 clear_i,
  input  logic [4:0]           addr_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 valid_o,
  output logic [4:0]           addr_o,
  output logic [DataWidth-1:0] data_o
);

  logic                 valid_q, valid_d;
  logic [4:0]           addr_q, addr_d;
  logic [DataWidth-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ibex_rf_writeback.sv
// Writeback arbiter for the single register-file write port: merges EX and LSU
// results, tracks one outstanding load, skids a colliding EX result, flags RAW hazards.
module ibex_rf_writeback
  import ibex_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 lsu_req_i,
  input  logic [4:0]           lsu_req_waddr_i,
  output logic                 lsu_req_ready_o,
  input  logic                 lsu_rvalid_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  input  logic                 lsu_err_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 hazard_o,
  output logic                 load_pending_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o
);

  ld_state_e            ld_state_q, ld_state_d;
  logic [4:0]           pend_waddr_q, pend_waddr_d;
  logic                 rf_we_q, rf_we_d;
  logic [4:0]           rf_waddr_q, rf_waddr_d;
  logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;

  logic [4:0] ex_waddr_m, lsu_req_waddr_m, raddr_a_m, raddr_b_m;
  logic       lsu_resp, lsu_write, ex_accept, ex_write, lsu_req_accept;
  logic       skid_valid, skid_load, skid_clear;
  logic [4:0] skid_waddr;
  logic [DataWidth-1:0] skid_wdata;
  wb_src_e    wb_src;
  logic       hazard_a, hazard_b;

  assign ex_waddr_m      = wb_addr_mask(ex_waddr_i, RV32E);
  assign lsu_req_waddr_m = wb_addr_mask(lsu_req_waddr_i, RV32E);
  assign raddr_a_m       = wb_addr_mask(raddr_a_i, RV32E);
  assign raddr_b_m       = wb_addr_mask(raddr_b_i, RV32E);

  // Erroring or x0-targeted responses close the load but never claim the write port.
  assign lsu_resp       = (ld_state_q == LD_WAIT) & lsu_rvalid_i;
  assign lsu_write      = lsu_resp & ~lsu_err_i & (pend_waddr_q != 5'd0);
  assign ex_ready_o     = ~skid_valid;
  assign ex_accept      = ex_valid_i & ex_ready_o;
  assign ex_write       = ex_accept & (ex_waddr_m != 5'd0);
  assign lsu_req_ready_o = (ld_state_q == LD_IDLE) | lsu_rvalid_i;
  assign lsu_req_accept = lsu_req_i & lsu_req_ready_o;
  assign load_pending_o = (ld_state_q == LD_WAIT);

  always_comb begin
    ld_state_d   = ld_state_q;
    pend_waddr_d = pend_waddr_q;
    case (ld_state_q)
      LD_IDLE: begin
        if (lsu_req_accept) begin
          ld_state_d   = LD_WAIT;
          pend_waddr_d = lsu_req_waddr_m;
        end
      end
      LD_WAIT: begin
        if (lsu_rvalid_i) begin
          if (lsu_req_i) begin
            pend_waddr_d = lsu_req_waddr_m;
          end else begin
            ld_state_d = LD_IDLE;
          end
        end
      end
      default: ld_state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ld_state_q   <= LD_IDLE;
      pend_waddr_q <= 5'd0;
    end else begin
      ld_state_q   <= ld_state_d;
      pend_waddr_q <= pend_waddr_d;
    end
  end

  // Load response beats skid, skid beats a fresh EX result; a displaced EX result is skidded.
  always_comb begin
    wb_src     = WB_NONE;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (lsu_write) begin
      wb_src    = WB_LSU;
      skid_load = ex_write;
    end else if (skid_valid) begin
      wb_src     = WB_SKID;
      skid_clear = 1'b1;
    end else if (ex_write) begin
      wb_src = WB_EX;
    end
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    case (wb_src)
      WB_LSU: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = pend_waddr_q;
        rf_wdata_d = lsu_rdata_i;
      end
      WB_SKID: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = skid_waddr;
        rf_wdata_d = skid_wdata;
      end
      WB_EX: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = ex_waddr_m;
        rf_wdata_d = ex_wdata_i;
      end
      default: rf_we_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;

  ibex_rf_wb_skid #(
    .DataWidth(DataWidth)
  ) u_skid (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (skid_load),
    .clear_i(skid_clear),
    .addr_i (ex_waddr_m),
    .data_i (ex_wdata_i),
    .valid_o(skid_valid),
    .addr_o (skid_waddr),
    .data_o (skid_wdata)
  );

  // x0 reads never stall; all other reads wait on any write not yet in the register file.
  always_comb begin
    hazard_a = (raddr_a_m != 5'd0) &
               ((load_pending_o & (raddr_a_m == pend_waddr_q)) |
                (skid_valid & (raddr_a_m == skid_waddr)) |
                (rf_we_q & (raddr_a_m == rf_waddr_q)));
    hazard_b = (raddr_b_m != 5'd0) &
               ((load_pending_o & (raddr_b_m == pend_waddr_q)) |
                (skid_valid & (raddr_b_m == skid_waddr)) |
                (rf_we_q & (raddr_b_m == rf_waddr_q)));
  end

  assign hazard_o = hazard_a | hazard_b;

endmodule

// File: tb/tb_ibex_rf_writeback.sv
// Scoreboard bench for ibex_rf_writeback: expected writes are queued as stimulus is
// driven and popped whenever the DUT pulses rf_we_o; a second RV32E instance shares inputs.
module tb_ibex_rf_writeback;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst_ni;
  logic        ex_valid;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        lsu_req;
  logic [4:0]  lsu_req_waddr;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;

  logic        ex_ready, lsu_req_ready, hazard, load_pending, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        e_ex_ready, e_lsu_req_ready, e_hazard, e_load_pending, e_rf_we;
  logic [4:0]  e_rf_waddr;
  logic [31:0] e_rf_wdata;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];

  ibex_rf_writeback #(.RV32E(1'b0), .DataWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(ex_ready),
    .lsu_req_i(lsu_req), .lsu_req_waddr_i(lsu_req_waddr), .lsu_req_ready_o(lsu_req_ready),
    .lsu_rvalid_i(lsu_rvalid), .lsu_rdata_i(lsu_rdata), .lsu_err_i(lsu_err),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .hazard_o(hazard), .load_pending_o(load_pending),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata)
  );

  ibex_rf_writeback #(.RV32E(1'b1), .DataWidth(32)) dut_e (
    .clk_i(clk), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(e_ex_ready),
    .lsu_req_i(lsu_req), .lsu_req_waddr_i(lsu_req_waddr), .lsu_req_ready_o(e_lsu_req_ready),
    .lsu_rvalid_i(lsu_rvalid), .lsu_rdata_i(lsu_rdata), .lsu_err_i(lsu_err),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .hazard_o(e_hazard), .load_pending_o(e_load_pending),
    .rf_we_o(e_rf_we), .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every write pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (rst_ni && rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got x%0d=%h, required no write", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
          errors++;
          $display("[TB] FAIL write_data: got x%0d=%h, required x%0d=%h", rf_waddr, rf_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'd0;
    lsu_req = 1'b0; lsu_req_waddr = 5'd0;
    lsu_rvalid = 1'b0; lsu_rdata = 32'd0; lsu_err = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks += 7;
    if (rf_we !== 1'b0)         begin errors++; $display("[TB] FAIL reset_we: got %b, required 0", rf_we); end
    if (rf_waddr !== 5'd0)      begin errors++; $display("[TB] FAIL reset_waddr: got %0d, required 0", rf_waddr); end
    if (rf_wdata !== 32'd0)     begin errors++; $display("[TB] FAIL reset_wdata: got %h, required 0", rf_wdata); end
    if (ex_ready !== 1'b1)      begin errors++; $display("[TB] FAIL reset_ex_ready: got %b, required 1", ex_ready); end
    if (lsu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_lsu_ready: got %b, required 1", lsu_req_ready); end
    if (load_pending !== 1'b0)  begin errors++; $display("[TB] FAIL reset_pending: got %b, required 0", load_pending); end
    if (hazard !== 1'b0)        begin errors++; $display("[TB] FAIL reset_hazard: got %b, required 0", hazard); end
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_ex_write();
    ex_valid = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'hDEADBEEF;
    exp_q.push_back('{5'd5, 32'hDEADBEEF});
    @(negedge clk);
    checks++;
    if (ex_ready !== 1'b1) begin errors++; $display("[TB] FAIL ex_ready_accept: got %b, required 1", ex_ready); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks += 2;
    if (rf_we !== 1'b1)    begin errors++; $display("[TB] FAIL ex_write_we: got %b, required 1", rf_we); end
    if (ex_ready !== 1'b1) begin errors++; $display("[TB] FAIL ex_ready_after: got %b, required 1", ex_ready); end
    tick();
  endtask

  task automatic test_load_skid();
    lsu_req = 1'b1; lsu_req_waddr = 5'd7;
    @(negedge clk);
    checks++;
    if (lsu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL ld_req_ready: got %b, required 1", lsu_req_ready); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks += 2;
    if (load_pending !== 1'b1)  begin errors++; $display("[TB] FAIL ld_pending: got %b, required 1", load_pending); end
    if (lsu_req_ready !== 1'b0) begin errors++; $display("[TB] FAIL ld_ready_wait: got %b, required 0", lsu_req_ready); end
    tick();
    lsu_rvalid = 1'b1; lsu_rdata = 32'h1234;
    ex_valid = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'hA5;
    exp_q.push_back('{5'd7, 32'h1234});
    exp_q.push_back('{5'd3, 32'hA5});
    @(negedge clk);
    checks++;
    if (ex_ready !== 1'b1) begin errors++; $display("[TB] FAIL skid_ex_ready_in: got %b, required 1", ex_ready); end
    tick();
    idle_inputs();
    raddr_a = 5'd3;
    @(negedge clk);
    checks += 4;
    if (rf_we !== 1'b1)        begin errors++; $display("[TB] FAIL skid_lsu_we: got %b, required 1", rf_we); end
    if (ex_ready !== 1'b0)     begin errors++; $display("[TB] FAIL skid_ex_ready_full: got %b, required 0", ex_ready); end
    if (load_pending !== 1'b0) begin errors++; $display("[TB] FAIL skid_pending: got %b, required 0", load_pending); end
    if (hazard !== 1'b1)       begin errors++; $display("[TB] FAIL skid_hazard: got %b, required 1", hazard); end
    tick();
    @(negedge clk);
    checks += 2;
    if (rf_we !== 1'b1)    begin errors++; $display("[TB] FAIL skid_drain_we: got %b, required 1", rf_we); end
    if (ex_ready !== 1'b1) begin errors++; $display("[TB] FAIL skid_ex_ready_out: got %b, required 1", ex_ready); end
    raddr_a = 5'd0;
    tick();
  endtask

  task automatic test_load_error();
    lsu_req = 1'b1; lsu_req_waddr = 5'd9;
    tick();
    idle_inputs();
    lsu_rvalid = 1'b1; lsu_err = 1'b1; lsu_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    checks++;
    if (load_pending !== 1'b1) begin errors++; $display("[TB] FAIL err_pending_before: got %b, required 1", load_pending); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks += 3;
    if (rf_we !== 1'b0)         begin errors++; $display("[TB] FAIL err_no_write: got %b, required 0", rf_we); end
    if (load_pending !== 1'b0)  begin errors++; $display("[TB] FAIL err_pending_after: got %b, required 0", load_pending); end
    if (lsu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL err_req_ready: got %b, required 1", lsu_req_ready); end
    tick();
  endtask

  task automatic test_x0();
    ex_valid = 1'b1; ex_waddr = 5'd0; ex_wdata = 32'hFFFFFFFF;
    raddr_a = 5'd0; raddr_b = 5'd0;
    @(negedge clk);
    checks += 2;
    if (ex_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0_ex_ready: got %b, required 1", ex_ready); end
    if (hazard !== 1'b0)   begin errors++; $display("[TB] FAIL x0_hazard: got %b, required 0", hazard); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks += 2;
    if (rf_we !== 1'b0)    begin errors++; $display("[TB] FAIL x0_no_write: got %b, required 0", rf_we); end
    if (ex_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0_no_skid: got %b, required 1", ex_ready); end
    tick();
  endtask

  task automatic test_hazard();
    lsu_req = 1'b1; lsu_req_waddr = 5'd12;
    raddr_a = 5'd28; raddr_b = 5'd12;
    tick();
    idle_inputs();
    @(negedge clk);
    checks += 2;
    if (hazard !== 1'b1)   begin errors++; $display("[TB] FAIL hz_pending: got %b, required 1", hazard); end
    if (e_hazard !== 1'b1) begin errors++; $display("[TB] FAIL hz_rv32e: got %b, required 1", e_hazard); end
    raddr_b = 5'd0;
    @(negedge clk);
    checks += 2;
    if (hazard !== 1'b0)   begin errors++; $display("[TB] FAIL hz_raddr28_full: got %b, required 0", hazard); end
    if (e_hazard !== 1'b1) begin errors++; $display("[TB] FAIL hz_raddr28_e: got %b, required 1", e_hazard); end
    raddr_b = 5'd12;
    tick();
    lsu_rvalid = 1'b1; lsu_rdata = 32'h00C0FFEE;
    exp_q.push_back('{5'd12, 32'h00C0FFEE});
    @(negedge clk);
    checks++;
    if (hazard !== 1'b1) begin errors++; $display("[TB] FAIL hz_resp_cycle: got %b, required 1", hazard); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks += 3;
    if (hazard !== 1'b1)       begin errors++; $display("[TB] FAIL hz_write_cycle: got %b, required 1", hazard); end
    if (e_rf_we !== 1'b1)      begin errors++; $display("[TB] FAIL hz_e_we: got %b, required 1", e_rf_we); end
    if (e_rf_waddr !== 5'd12)  begin errors++; $display("[TB] FAIL hz_e_waddr: got %0d, required 12", e_rf_waddr); end
    tick();
    @(negedge clk);
    checks += 2;
    if (hazard !== 1'b0)   begin errors++; $display("[TB] FAIL hz_clear: got %b, required 0", hazard); end
    if (e_hazard !== 1'b0) begin errors++; $display("[TB] FAIL hz_clear_e: got %b, required 0", e_hazard); end
    raddr_a = 5'd0; raddr_b = 5'd0;
    tick();
  endtask

  task automatic test_rv32e_addr();
    ex_valid = 1'b1; ex_waddr = 5'd21; ex_wdata = 32'h77;
    exp_q.push_back('{5'd21, 32'h77});
    tick();
    idle_inputs();
    @(negedge clk);
    checks += 2;
    if (e_rf_we !== 1'b1)    begin errors++; $display("[TB] FAIL e_we: got %b, required 1", e_rf_we); end
    if (e_rf_waddr !== 5'd5) begin errors++; $display("[TB] FAIL e_waddr_fold: got %0d, required 5", e_rf_waddr); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 1; i <= 4; i++) begin
      d = $urandom;
      ex_valid = 1'b1; ex_waddr = 5'(i + 16); ex_wdata = d;
      exp_q.push_back('{5'(i + 16), d});
      @(negedge clk);
      checks++;
      if (ex_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_%0d: got %b, required 1", i, ex_ready); end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    tick();
  endtask

  task automatic test_reset_midop();
    lsu_req = 1'b1; lsu_req_waddr = 5'd10;
    tick();
    idle_inputs();
    lsu_rvalid = 1'b1; lsu_rdata = 32'h1010;
    lsu_req = 1'b1; lsu_req_waddr = 5'd13;
    ex_valid = 1'b1; ex_waddr = 5'd11; ex_wdata = 32'h1111;
    tick();
    idle_inputs();
    checks += 2;
    if (load_pending !== 1'b1) begin errors++; $display("[TB] FAIL mid_pending: got %b, required 1", load_pending); end
    if (ex_ready !== 1'b0)     begin errors++; $display("[TB] FAIL mid_skid_full: got %b, required 0", ex_ready); end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_we: got %b, required 0", rf_we); end
    @(negedge clk);
    rst_ni = 1'b1;
    raddr_a = 5'd13; raddr_b = 5'd11;
    tick();
    lsu_rvalid = 1'b1; lsu_rdata = 32'h1313;
    tick();
    idle_inputs();
    @(negedge clk);
    checks += 6;
    if (rf_we !== 1'b0)         begin errors++; $display("[TB] FAIL late_resp_we: got %b, required 0", rf_we); end
    if (rf_waddr !== 5'd0)      begin errors++; $display("[TB] FAIL late_resp_waddr: got %0d, required 0", rf_waddr); end
    if (ex_ready !== 1'b1)      begin errors++; $display("[TB] FAIL late_ex_ready: got %b, required 1", ex_ready); end
    if (lsu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL late_req_ready: got %b, required 1", lsu_req_ready); end
    if (load_pending !== 1'b0)  begin errors++; $display("[TB] FAIL late_pending: got %b, required 0", load_pending); end
    if (hazard !== 1'b0)        begin errors++; $display("[TB] FAIL late_hazard: got %b, required 0", hazard); end
    raddr_a = 5'd0; raddr_b = 5'd0;
    tick();
  endtask

  initial begin
    rst_ni = 1'b0;
    raddr_a = 5'd0; raddr_b = 5'd0;
    idle_inputs();
    test_reset();
    test_ex_write();
    test_load_skid();
    test_load_error();
    test_x0();
    test_hazard();
    test_rv32e_addr();
    test_back_to_back();
    test_reset_midop();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_writes: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
